// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types: machine widths, FSM encoding and the queue entry layout.
package riscv_fetch_pkg;

    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries; flush wins over push/pop, slots clear on reset.
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         full
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];
    assign full = (count == (AW+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Stale slot contents are left in place; count==0 hides them.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, queues returned instructions for decode,
// and handles branch redirects (flush) and misaligned targets (sticky halt).
module instr_fetch_unit #(
    parameter int XLEN = riscv_fetch_pkg::XLEN,
    parameter int ILEN = riscv_fetch_pkg::ILEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_fetch_pkg::RESET_PC,
    parameter int QDEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_pc,
    input  logic [ILEN-1:0] imem_instr,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [ILEN-1:0] dec_instr,
    output logic            fetch_halted,
    output logic [XLEN-1:0] halt_pc
);

    import riscv_fetch_pkg::*;

    localparam int AW = $clog2(QDEPTH);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] fetch_pc;
    logic            push, pop, flush, q_full;
    logic            redirect_ok, redirect_bad;
    logic [AW:0]     q_count;
    fetch_entry_t    q_wdata, q_head;

    assign imem_pc      = fetch_pc;
    assign redirect_ok  = (state == RUN) && redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = (state == RUN) && redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign flush        = redirect_ok || redirect_bad;

    // Decode handshake: an entry transfers on a cycle where dec_valid && dec_ready;
    // dec_pc/dec_instr come from the head slot and stay put until that transfer.
    // A redirect in flight masks dec_valid so a wrong-path entry is never consumed.
    assign dec_valid = (q_count != '0) && !redirect_valid && (state != HALT);
    assign pop       = dec_valid && dec_ready;
    assign push      = (state == RUN) && fetch_en && !redirect_valid && (!q_full || pop);
    assign dec_pc    = q_head.pc;
    assign dec_instr = q_head.instr;

    assign q_wdata.pc    = fetch_pc;
    assign q_wdata.instr = imem_instr;

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (q_wdata),
        .head  (q_head),
        .count (q_count),
        .full  (q_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (redirect_bad) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            fetch_halted <= 1'b0;
            halt_pc      <= '0;
        end else begin
            if (redirect_ok)
                fetch_pc <= redirect_pc;
            else if (push)
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            // Only reachable from RUN, so the first offending target is kept.
            if (redirect_bad) begin
                fetch_halted <= 1'b1;
                halt_pc      <= redirect_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of expected {pc, instr}
// entries consumed at decode, plus per-scenario inline timing checks.
module tb_instr_fetch_unit;

    localparam int W = 96;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        fetch_en = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [63:0] dec_pc;
    logic [31:0] dec_instr;
    logic        fetch_halted;
    logic [63:0] halt_pc;

    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .fetch_halted   (fetch_halted),
        .halt_pc        (halt_pc)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] mem_model(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h015A04B3;
            64'h4:   return 32'h00148B93;
            64'h8:   return 32'hF0953823;
            64'h54:  return 32'h014AEA13;
            default: return a[31:0] ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign imem_instr = mem_model(imem_pc);

    // scoreboard: every decode transfer must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready) begin
            logic [W-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no transfer", dec_pc, dec_instr);
            end else begin
                e = exp_q.pop_front();
                if ({dec_pc, dec_instr} !== e) begin
                    errors++;
                    $display("FAIL sb_entry: got pc=%h instr=%h, required pc=%h instr=%h",
                             dec_pc, dec_instr, e[95:32], e[31:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic apply_reset(input logic rdy);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        fetch_en = 1'b1;
        dec_ready = rdy;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic expect_entry(input logic [63:0] pc);
        exp_q.push_back({pc, mem_model(pc)});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1 dec_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks += 6;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b required 0", dec_valid); end
        if (dec_pc !== 64'h0) begin errors++; $display("FAIL reset_dec_pc: got %h required 0", dec_pc); end
        if (dec_instr !== 32'h0) begin errors++; $display("FAIL reset_dec_instr: got %h required 0", dec_instr); end
        if (imem_pc !== 64'h0) begin errors++; $display("FAIL reset_imem_pc: got %h required 0", imem_pc); end
        if (fetch_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", fetch_halted); end
        if (halt_pc !== 64'h0) begin errors++; $display("FAIL reset_halt_pc: got %h required 0", halt_pc); end
    endtask

    task automatic test_stream();
        apply_reset(1'b1);
        expect_entry(64'h0);
        expect_entry(64'h4);
        expect_entry(64'h8);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL stream_edge1_valid: got %b required 0", dec_valid); end
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (dec_valid !== 1'b1) begin errors++; $display("FAIL stream_edge2_valid: got %b required 1", dec_valid); end
        if (dec_pc !== 64'h0) begin errors++; $display("FAIL stream_edge2_pc: got %h required 0", dec_pc); end
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain: %0d entries left, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks += 3;
            if (dec_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b required 1", i, dec_valid); end
            if (dec_pc !== 64'h0) begin errors++; $display("FAIL bp_pc_hold[%0d]: got %h required 0", i, dec_pc); end
            if (dec_instr !== 32'h015A04B3) begin errors++; $display("FAIL bp_instr_hold[%0d]: got %h required 015a04b3", i, dec_instr); end
        end
        checks++;
        if (imem_pc !== 64'h8) begin errors++; $display("FAIL bp_fetch_pc: got %h required 8", imem_pc); end
        expect_entry(64'h0);
        expect_entry(64'h4);
        expect_entry(64'h8);
        @(posedge clk);
        #1 dec_ready = 1'b1;
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d entries left, required 0", exp_q.size()); end
    endtask

    task automatic test_redirect_full();
        repeat (3) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h54;
        dec_ready = 1'b1;
        expect_entry(64'h54);
        expect_entry(64'h58);
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_same: got %b required 0", dec_valid); end
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_next: got %b required 0", dec_valid); end
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (dec_valid !== 1'b1) begin errors++; $display("FAIL redir_valid_2: got %b required 1", dec_valid); end
        if (dec_pc !== 64'h54) begin errors++; $display("FAIL redir_pc_2: got %h required 54", dec_pc); end
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL redir_drain: %0d entries left, required 0", exp_q.size()); end
    endtask

    task automatic test_misaligned();
        apply_reset(1'b0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h56;
        dec_ready = 1'b1;
        @(posedge clk);
        #1 redirect_pc = 64'h0;
        @(negedge clk);
        checks += 4;
        if (fetch_halted !== 1'b1) begin errors++; $display("FAIL mis_halted: got %b required 1", fetch_halted); end
        if (halt_pc !== 64'h56) begin errors++; $display("FAIL mis_halt_pc: got %h required 56", halt_pc); end
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b required 0", dec_valid); end
        if (imem_pc !== 64'h0) begin errors++; $display("FAIL mis_fetch_pc: got %h required 0", imem_pc); end
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (halt_pc !== 64'h56) begin errors++; $display("FAIL mis_halt_pc_keep: got %h required 56", halt_pc); end
        if (fetch_halted !== 1'b1) begin errors++; $display("FAIL mis_halted_keep: got %b required 1", fetch_halted); end
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL mis_valid_keep: got %b required 0", dec_valid); end
        if (imem_pc !== 64'h0) begin errors++; $display("FAIL mis_fetch_pc_keep: got %h required 0", imem_pc); end
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (fetch_halted !== 1'b0) begin errors++; $display("FAIL mis_reset_halted: got %b required 0", fetch_halted); end
        if (halt_pc !== 64'h0) begin errors++; $display("FAIL mis_reset_halt_pc: got %h required 0", halt_pc); end
    endtask

    task automatic test_idle_redirect();
        apply_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        expect_entry(64'h0);
        expect_entry(64'h4);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_pc !== 64'h0) begin errors++; $display("FAIL idle_redir_pc: got %h required 0", imem_pc); end
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL idle_redir_drain: %0d entries left, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        apply_reset(1'b1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        expect_entry(64'hFFFF_FFFF_FFFF_FFFC);
        expect_entry(64'h0);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_fetch_pc: got %h required fffffffffffffffc", imem_pc); end
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d entries left, required 0", exp_q.size()); end
    endtask

    task automatic test_fetch_en_reset();
        apply_reset(1'b1);
        expect_entry(64'h0);
        expect_entry(64'h4);
        expect_entry(64'h8);
        repeat (3) @(posedge clk);
        #1 fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (imem_pc !== 64'h8) begin errors++; $display("FAIL fen_hold_pc[%0d]: got %h required 8", i, imem_pc); end
        end
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL fen_pops_drained: got %b required 0", dec_valid); end
        fetch_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (dec_valid !== 1'b1) begin errors++; $display("FAIL fen_resume_valid: got %b required 1", dec_valid); end
        if (dec_pc !== 64'h8) begin errors++; $display("FAIL fen_resume_pc: got %h required 8", dec_pc); end
        @(posedge clk);
        #1 dec_ready = 1'b0;
        checks++;
        if (dec_valid !== 1'b1) begin errors++; $display("FAIL fen_pre_reset_valid: got %b required 1", dec_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b required 0", dec_valid); end
        if (dec_pc !== 64'h0) begin errors++; $display("FAIL async_rst_pc: got %h required 0", dec_pc); end
        if (dec_instr !== 32'h0) begin errors++; $display("FAIL async_rst_instr: got %h required 0", dec_instr); end
        if (imem_pc !== 64'h0) begin errors++; $display("FAIL async_rst_imem_pc: got %h required 0", imem_pc); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fen_drain: %0d entries left, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        test_idle_redirect();
        test_wrap();
        test_fetch_en_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
